// File: rtl/per_arb_pkg.sv
// Shared types and defaults for the per-slave round-robin arbiter.
package per_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } per_state_e;

    localparam int N_MASTER_DEFAULT = 16;
    localparam int LOG_MASTER       = $clog2(N_MASTER_DEFAULT);
    localparam int MAX_OUT_DEFAULT  = 4;
    localparam int CNT_WIDTH        = $clog2(MAX_OUT_DEFAULT + 1);

    // Next round-robin start position after granting master 'sel' out of 'n'.
    function automatic int rr_next(input int sel, input int n);
        return (sel == n - 1) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/per_slave_rr_arbiter_rr_prio_sel.sv
// Combinational round-robin pick: first asserted request at or after prio, wrapping.
// Zero latency; no backpressure (pure function of req/prio).
module rr_prio_sel #(
    parameter int N_MASTER = 16,
    parameter int SEL_W    = $clog2(N_MASTER)
) (
    input  logic [N_MASTER-1:0] req,
    input  logic [SEL_W-1:0]    prio,
    output logic [SEL_W-1:0]    sel,
    output logic                any
);

    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (!any && req[(int'(prio) + k) % N_MASTER]) begin
                any = 1'b1;
                sel = SEL_W'((int'(prio) + k) % N_MASTER);
            end
        end
    end

endmodule

// File: rtl/per_slave_rr_arbiter.sv
// Per-slave round-robin arbiter: same-cycle grant, pick held until the slave accepts,
// outstanding cap stalls requests; responses routed back by one-hot ID one cycle later.
module per_slave_rr_arbiter
    import per_arb_pkg::*;
#(
    parameter int N_MASTER        = N_MASTER_DEFAULT,
    parameter int ID_WIDTH        = 17,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = MAX_OUT_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_MASTER-1:0]                   data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0]        data_add_i,
    input  logic [N_MASTER-1:0]                   data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0]        data_wdata_i,
    input  logic [N_MASTER*(DATA_WIDTH/8)-1:0]    data_be_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]          data_ID_i,
    output logic [N_MASTER-1:0]                   data_gnt_o,
    output logic                                  per_req_o,
    output logic [ADDR_WIDTH-1:0]                 per_add_o,
    output logic                                  per_wen_o,
    output logic [DATA_WIDTH-1:0]                 per_wdata_o,
    output logic [DATA_WIDTH/8-1:0]               per_be_o,
    output logic [ID_WIDTH-1:0]                   per_ID_o,
    input  logic                                  per_gnt_i,
    input  logic                                  per_r_valid_i,
    input  logic [ID_WIDTH-1:0]                   per_r_ID_i,
    input  logic [DATA_WIDTH-1:0]                 per_r_rdata_i,
    input  logic                                  per_r_opc_i,
    output logic [N_MASTER-1:0]                   data_r_valid_o,
    output logic [DATA_WIDTH-1:0]                 data_r_rdata_o,
    output logic                                  data_r_opc_o
);

    localparam int SEL_W = $clog2(N_MASTER);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    per_state_e         state_q, state_d;
    logic [SEL_W-1:0]   prio_q, sel_q, rr_sel, sel;
    logic               rr_any, full, per_req, handshake;
    logic [CNT_W-1:0]   out_cnt;

    rr_prio_sel #(
        .N_MASTER (N_MASTER),
        .SEL_W    (SEL_W)
    ) u_rr_prio_sel (
        .req  (data_req_i),
        .prio (prio_q),
        .sel  (rr_sel),
        .any  (rr_any)
    );

    // Registered count only: a response in the same cycle cannot lift a full stall.
    assign full = (out_cnt == CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        state_d = state_q;
        sel     = rr_sel;
        per_req = 1'b0;
        case (state_q)
            IDLE: begin
                sel     = rr_sel;
                per_req = rr_any & ~full;
                if (per_req && !per_gnt_i) state_d = LOCKED;
            end
            LOCKED: begin
                sel     = sel_q;
                per_req = data_req_i[sel_q] & ~full;
                if (!data_req_i[sel_q] || (per_req && per_gnt_i)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) per_req = 1'b0;
    end

    assign handshake = per_req & per_gnt_i;
    assign per_req_o = per_req;

    always_comb begin
        data_gnt_o = '0;
        if (handshake) data_gnt_o[sel] = 1'b1;
    end

    assign per_add_o   = per_req ? data_add_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH]   : '0;
    assign per_wdata_o = per_req ? data_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign per_be_o    = per_req ? data_be_i[int'(sel)*BE_W +: BE_W]                : '0;
    assign per_ID_o    = per_req ? data_ID_i[int'(sel)*ID_WIDTH +: ID_WIDTH]        : '0;
    assign per_wen_o   = per_req & data_wen_i[sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            prio_q         <= '0;
            sel_q          <= '0;
            out_cnt        <= '0;
            data_r_valid_o <= '0;
            data_r_rdata_o <= '0;
            data_r_opc_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (per_req && !per_gnt_i) sel_q <= sel;
            if (handshake) prio_q <= SEL_W'(rr_next(int'(sel), N_MASTER));
            case ({handshake, per_r_valid_i})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - CNT_W'(1);
                default: ;
            endcase
            data_r_valid_o <= per_r_valid_i ? per_r_ID_i[N_MASTER-1:0] : '0;
            if (per_r_valid_i) begin
                data_r_rdata_o <= per_r_rdata_i;
                data_r_opc_o   <= per_r_opc_i;
            end
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(data_gnt_o));
    a_lock_stable: assert property (@(posedge clk) disable iff (rst)
        (per_req && !per_gnt_i) |=> (state_q == LOCKED && sel_q == $past(sel)));
    a_no_req_drop: assert property (@(posedge clk) disable iff (rst)
        (state_q == LOCKED) |-> data_req_i[sel_q]);
    a_resp_legal: assert property (@(posedge clk) disable iff (rst)
        per_r_valid_i |-> (out_cnt != '0 && $onehot(per_r_ID_i)));

endmodule
